// File: rtl/fmap_stream_if.sv
// Word stream carrying one feature-map value plus its (channel, row, column) tag.
interface fmap_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 6,
    parameter int OUT_H      = 28,
    parameter int OUT_W      = 28
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW-1:0]         out_chan;
    logic [RW-1:0]         out_row;
    logic [XW-1:0]         out_col;
    logic                  out_last;

    modport master (
        output out_data, out_valid, out_chan, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_chan, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/fmap_stream_out.sv
// Unloads a flat word-packed feature-map bus as a tagged valid/ready word stream.
module fmap_stream_out #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 6,
    parameter int OUT_H      = 28,
    parameter int OUT_W      = 28,
    localparam int N         = CHANNELS * OUT_H * OUT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N*DATA_WIDTH-1:0] fmap_in,
    fmap_stream_if.master           stream,
    output logic                    busy,
    output logic                    done
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state_reg, state_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [CW-1:0]         chan_reg, chan_next;
    logic [RW-1:0]         row_reg, row_next;
    logic [XW-1:0]         col_reg, col_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  valid_reg, valid_next;
    logic                  last_reg, last_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;

    logic [DATA_WIDTH-1:0] words [N];
    logic [IW-1:0]         idx_inc;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign words[gi] = fmap_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign idx_inc = idx_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        chan_next  = chan_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    idx_next   = '0;
                    chan_next  = '0;
                    row_next   = '0;
                    col_next   = '0;
                    data_next  = words[0];
                    valid_next = 1'b1;
                    last_next  = (N == 1);
                    busy_next  = 1'b1;
                end
            end
            STREAM: begin
                if (valid_reg && stream.out_ready) begin
                    if (idx_reg == IW'(N - 1)) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next  = idx_inc;
                        data_next = words[idx_inc];
                        last_next = (idx_inc == IW'(N - 1));
                        // Raster order: column fastest, then row, then channel.
                        if (col_reg == XW'(OUT_W - 1)) begin
                            col_next = '0;
                            if (row_reg == RW'(OUT_H - 1)) begin
                                row_next  = '0;
                                chan_next = chan_reg + 1'b1;
                            end else begin
                                row_next = row_reg + 1'b1;
                            end
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b0;
                busy_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            chan_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            chan_reg  <= chan_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign stream.out_data  = data_reg;
    assign stream.out_valid = valid_reg;
    assign stream.out_chan  = chan_reg;
    assign stream.out_row   = row_reg;
    assign stream.out_col   = col_reg;
    assign stream.out_last  = last_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
endmodule

// File: tb/tb_fmap_stream_out.sv
// Drives a full-size and a reduced-size unloader and checks every word against a raster-order model.
module tb_fmap_stream_out;
    localparam int DW  = 16;
    localparam int CD  = 6;
    localparam int HD  = 28;
    localparam int WD  = 28;
    localparam int ND  = CD * HD * WD;
    localparam int CS  = 2;
    localparam int HS  = 3;
    localparam int WS  = 3;
    localparam int NS  = CS * HS * WS;

    logic clk = 1'b0;
    logic reset;
    logic start_d, start_s;
    logic [ND*DW-1:0] fmap_d;
    logic [NS*DW-1:0] fmap_s;
    logic busy_d, done_d, busy_s, done_s;

    logic [DW-1:0] mem_d [ND];
    logic [DW-1:0] mem_s [NS];

    int checks = 0;
    int errors = 0;

    fmap_stream_if #(.DATA_WIDTH(DW), .CHANNELS(CD), .OUT_H(HD), .OUT_W(WD)) sd ();
    fmap_stream_if #(.DATA_WIDTH(DW), .CHANNELS(CS), .OUT_H(HS), .OUT_W(WS)) ss ();

    fmap_stream_out #(.DATA_WIDTH(DW), .CHANNELS(CD), .OUT_H(HD), .OUT_W(WD)) dut_d (
        .clk(clk), .reset(reset), .start(start_d), .fmap_in(fmap_d),
        .stream(sd.master), .busy(busy_d), .done(done_d)
    );

    fmap_stream_out #(.DATA_WIDTH(DW), .CHANNELS(CS), .OUT_H(HS), .OUT_W(WS)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .fmap_in(fmap_s),
        .stream(ss.master), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    task automatic fill_default(input bit random_words);
        for (int i = 0; i < ND; i++) begin
            mem_d[i] = random_words ? DW'($urandom) : DW'(i);
            fmap_d[i*DW +: DW] = mem_d[i];
        end
    endtask

    // Streams one full frame from the default DUT; ready is high with probability ready_pct.
    task automatic run_stream(input string name, input int ready_pct, input bit poke_start);
        int exp_i = 0;
        int cyc = 0;
        bit finished = 0;
        logic [2:0] ec;
        logic [4:0] er, ex;
        @(negedge clk);
        start_d = 1'b1;
        sd.out_ready = 1'b0;
        while (!finished && cyc < 4 * ND + 100) begin
            @(negedge clk);
            cyc++;
            start_d = 1'b0;
            ec = 3'(exp_i / (HD * WD));
            er = 5'((exp_i / WD) % HD);
            ex = 5'(exp_i % WD);
            checks++;
            if (sd.out_valid !== 1'b1 || busy_d !== 1'b1) begin
                errors++;
                $display("FAIL %s valid/busy word %0d: got valid=%b busy=%b want 1/1", name, exp_i, sd.out_valid, busy_d);
            end
            checks++;
            if (sd.out_data !== mem_d[exp_i]) begin
                errors++;
                $display("FAIL %s data word %0d: got %h want %h", name, exp_i, sd.out_data, mem_d[exp_i]);
            end
            checks++;
            if (sd.out_chan !== ec || sd.out_row !== er || sd.out_col !== ex) begin
                errors++;
                $display("FAIL %s coord word %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, exp_i,
                         sd.out_chan, sd.out_row, sd.out_col, ec, er, ex);
            end
            checks++;
            if (sd.out_last !== (exp_i == ND - 1)) begin
                errors++;
                $display("FAIL %s last word %0d: got %b want %b", name, exp_i, sd.out_last, exp_i == ND - 1);
            end
            if (poke_start && (exp_i == 10 || exp_i == ND - 1)) start_d = 1'b1;
            sd.out_ready = ($urandom_range(99) < ready_pct);
            if (sd.out_ready && sd.out_valid === 1'b1) begin
                if (exp_i == ND - 1) finished = 1;
                exp_i++;
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: got %0d words want %0d", name, exp_i, ND);
        end
        if (ready_pct >= 100) begin
            checks++;
            if (cyc != ND) begin
                errors++;
                $display("FAIL %s throughput: got %0d cycles want %0d", name, cyc, ND);
            end
        end
        @(negedge clk);
        start_d = poke_start;
        sd.out_ready = 1'b0;
        checks++;
        if (done_d !== 1'b1 || busy_d !== 1'b1 || sd.out_valid !== 1'b0 || sd.out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle: got done=%b busy=%b valid=%b last=%b want 1 1 0 0",
                     name, done_d, busy_d, sd.out_valid, sd.out_last);
        end
        @(negedge clk);
        start_d = 1'b0;
        checks++;
        if (done_d !== 1'b0 || busy_d !== 1'b0 || sd.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after done: got done=%b busy=%b valid=%b want 0 0 0",
                     name, done_d, busy_d, sd.out_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start_d = 1'b0;
        start_s = 1'b0;
        sd.out_ready = 1'b0;
        ss.out_ready = 1'b0;
        fill_default(1'b0);
        for (int i = 0; i < NS; i++) fmap_s[i*DW +: DW] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (sd.out_valid !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0 || sd.out_data !== '0 ||
            sd.out_last !== 1'b0 || ss.out_valid !== 1'b0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL reset state: got valid=%b busy=%b done=%b data=%h want all 0",
                     sd.out_valid, busy_d, done_d, sd.out_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_stream;
        fill_default(1'b0);
        run_stream("full_stream", 100, 1'b0);
    endtask

    task automatic test_backpressure;
        fill_default(1'b1);
        run_stream("backpressure", 50, 1'b0);
    endtask

    task automatic test_start_while_busy;
        fill_default(1'b1);
        run_stream("start_busy", 70, 1'b1);
        run_stream("restart", 100, 1'b0);
    endtask

    task automatic test_reset_mid_stream;
        int xfers = 0;
        int cyc = 0;
        fill_default(1'b1);
        @(negedge clk);
        start_d = 1'b1;
        sd.out_ready = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        while (xfers < 100 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (sd.out_valid === 1'b1) xfers++;
        end
        reset = 1'b1;
        start_d = 1'b1;
        @(negedge clk);
        checks++;
        if (sd.out_valid !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0 || sd.out_data !== '0 ||
            sd.out_chan !== '0 || sd.out_row !== '0 || sd.out_col !== '0 || sd.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: got valid=%b busy=%b data=%h coord=(%0d,%0d,%0d) want all 0",
                     sd.out_valid, busy_d, sd.out_data, sd.out_chan, sd.out_row, sd.out_col);
        end
        reset = 1'b0;
        start_d = 1'b0;
        @(negedge clk);
        checks++;
        if (sd.out_valid !== 1'b0 || busy_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stays idle: got valid=%b busy=%b want 0 0", sd.out_valid, busy_d);
        end
        run_stream("after_reset", 80, 1'b0);
    endtask

    task automatic test_coord_wrap;
        int exp_i = 0;
        int cyc = 0;
        logic [0:0] ec;
        logic [1:0] er, ex;
        for (int i = 0; i < NS; i++) begin
            mem_s[i] = DW'($urandom);
            fmap_s[i*DW +: DW] = mem_s[i];
        end
        @(negedge clk);
        start_s = 1'b1;
        while (exp_i < NS && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_s = 1'b0;
            ec = 1'(exp_i / (HS * WS));
            er = 2'((exp_i / WS) % HS);
            ex = 2'(exp_i % WS);
            checks++;
            if (ss.out_valid !== 1'b1 || ss.out_data !== mem_s[exp_i] || ss.out_chan !== ec ||
                ss.out_row !== er || ss.out_col !== ex || ss.out_last !== (exp_i == NS - 1)) begin
                errors++;
                $display("FAIL coord_wrap word %0d: got v=%b d=%h (%0d,%0d,%0d) last=%b want v=1 d=%h (%0d,%0d,%0d) last=%b",
                         exp_i, ss.out_valid, ss.out_data, ss.out_chan, ss.out_row, ss.out_col, ss.out_last,
                         mem_s[exp_i], ec, er, ex, exp_i == NS - 1);
            end
            ss.out_ready = ($urandom_range(1) == 1);
            if (ss.out_ready && ss.out_valid === 1'b1) exp_i++;
        end
        checks++;
        if (exp_i != NS) begin
            errors++;
            $display("FAIL coord_wrap count: got %0d words want %0d", exp_i, NS);
        end
        @(negedge clk);
        ss.out_ready = 1'b0;
        checks++;
        if (done_s !== 1'b1 || ss.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL coord_wrap done: got done=%b valid=%b want 1 0", done_s, ss.out_valid);
        end
        @(negedge clk);
        checks++;
        if (done_s !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL coord_wrap idle: got done=%b busy=%b want 0 0", done_s, busy_s);
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_stream();
        test_coord_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
